frame_align: RTL and testbench

FRAME_ALIGN -- requirements
Module: frame_align

---
 rtl/frame_align.sv | 121 ++++++++++++
 tb/tb_frame_align.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_align.sv
// Frame aligner: hunts for the frame alignment word in an unaligned byte stream,
// confirms it one frame later, and emits the delayed stream with row/column position.
module frame_align #(
  parameter int          FRAME_COLS  = 64,
  parameter logic [47:0] FAS_PATTERN = 48'hF6F6F6282828,
  parameter int          OOF_MISSES  = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_frame_data,
  input  logic       i_frame_data_valid,
  output logic [7:0] o_frame_data,
  output logic       o_frame_data_valid,
  output logic       o_frame_data_fas,
  output logic [1:0] o_row_cnt,
  output logic [7:0] o_col_cnt,
  output logic       o_in_frame
);

  typedef enum logic [1:0] {HUNT, PRESYNC, SYNC} state_t;

  localparam logic [7:0] LAST_COL = 8'(FRAME_COLS - 1);
  localparam logic [2:0] MISS_MAX = 3'(OOF_MISSES);

  state_t      state, state_nxt;
  logic [39:0] sr;
  logic [47:0] window;
  logic        match;
  logic [2:0]  miss, miss_nxt, miss_inc;
  logic [1:0]  cur_row;
  logic [7:0]  cur_col;
  logic        at_zero;
  logic        fas_nxt;

  // Window's oldest byte is the one emitted on this beat, so FAS byte 0 leaves
  // on the same beat the final FAS byte arrives.
  assign window   = {sr, i_frame_data};
  assign match    = (window == FAS_PATTERN);
  assign miss_inc = miss + 3'd1;

  // Position of the beat being emitted now; HUNT pins it to the frame origin.
  always_comb begin
    cur_row = '0;
    cur_col = '0;
    if (state != HUNT) begin
      if (o_col_cnt == LAST_COL) begin
        cur_col = '0;
        cur_row = o_row_cnt + 2'd1;
      end else begin
        cur_col = o_col_cnt + 8'd1;
        cur_row = o_row_cnt;
      end
    end
  end

  assign at_zero = (cur_row == 2'd0) && (cur_col == 8'd0);

  always_comb begin
    state_nxt = state;
    miss_nxt  = miss;
    fas_nxt   = 1'b0;
    case (state)
      HUNT: begin
        miss_nxt = '0;
        if (match) state_nxt = PRESYNC;
      end
      PRESYNC: begin
        if (at_zero) begin
          if (match) begin
            state_nxt = SYNC;
            fas_nxt   = 1'b1;
            miss_nxt  = '0;
          end else begin
            state_nxt = HUNT;
          end
        end
      end
      SYNC: begin
        if (at_zero) begin
          if (match) begin
            fas_nxt  = 1'b1;
            miss_nxt = '0;
          end else if (miss_inc >= MISS_MAX) begin
            state_nxt = HUNT;
            miss_nxt  = '0;
          end else begin
            miss_nxt = miss_inc;
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state              <= HUNT;
      sr                 <= '0;
      miss               <= '0;
      o_frame_data       <= '0;
      o_frame_data_valid <= 1'b0;
      o_frame_data_fas   <= 1'b0;
      o_row_cnt          <= '0;
      o_col_cnt          <= '0;
      o_in_frame         <= 1'b0;
    end else begin
      o_frame_data_valid <= i_frame_data_valid;
      if (i_frame_data_valid) begin
        state            <= state_nxt;
        sr               <= window[39:0];
        miss             <= miss_nxt;
        o_frame_data     <= window[47:40];
        o_frame_data_fas <= fas_nxt;
        o_row_cnt        <= cur_row;
        o_col_cnt        <= cur_col;
        o_in_frame       <= (state_nxt == SYNC);
      end
    end
  end

endmodule

// File: tb/tb_frame_align.sv
// Directed bench for frame_align: lock, false lock, loss of frame, gapped input, mid-frame reset.
module tb_frame_align;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_frame_data = '0;
  logic       i_frame_data_valid = 1'b0;
  logic [7:0] o_frame_data;
  logic       o_frame_data_valid;
  logic       o_frame_data_fas;
  logic [1:0] o_row_cnt;
  logic [7:0] o_col_cnt;
  logic       o_in_frame;

  int total = 0;
  int bad   = 0;
  logic [15:0] bad_frames = '0;
  logic [7:0]  sent [0:2047];

  frame_align #(.FRAME_COLS(64), .FAS_PATTERN(48'hF6F6F6282828), .OOF_MISSES(3)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_frame_data(i_frame_data), .i_frame_data_valid(i_frame_data_valid),
    .o_frame_data(o_frame_data), .o_frame_data_valid(o_frame_data_valid),
    .o_frame_data_fas(o_frame_data_fas), .o_row_cnt(o_row_cnt),
    .o_col_cnt(o_col_cnt), .o_in_frame(o_in_frame)
  );

  always #5 i_clk = ~i_clk;

  // Stream byte k of a 256-byte framed stream; payload never contains 8'hF6.
  function automatic logic [7:0] fbyte(int k);
    logic [47:0] w;
    int c;
    w = 48'hF6F6F6282828;
    c = k % 256;
    if (c < 6) begin
      if (c == 5 && bad_frames[k / 256]) return 8'h00;
      return w[47 - 8 * c -: 8];
    end
    return 8'((k * 37 + 11) & 8'h7F);
  endfunction

  task automatic beat(input logic [7:0] d, input logic v, input logic r);
    @(negedge i_clk);
    i_frame_data = d;
    i_frame_data_valid = v;
    i_rst = r;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    beat(8'h00, 1'b0, 1'b1);
    beat(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    beat(8'hA5, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) beat(8'h00, 1'b0, 1'b0);
    total++;
    if ({o_frame_data, o_frame_data_valid, o_frame_data_fas, o_row_cnt, o_col_cnt, o_in_frame} !== '0) begin
      bad++;
      $display("FAIL reset_idle got data=%h v=%b fas=%b row=%0d col=%0d inf=%b, expected all 0",
               o_frame_data, o_frame_data_valid, o_frame_data_fas, o_row_cnt, o_col_cnt, o_in_frame);
    end
  endtask

  // Three clean frames; with gaps the per-beat outputs must match the gap-free result.
  task automatic test_lock(input bit gaps);
    logic [7:0] ed, last_d;
    logic [1:0] er, last_r;
    logic [7:0] ec, last_c;
    logic ef, ei;
    int p;
    bad_frames = '0;
    do_reset();
    last_d = '0; last_r = '0; last_c = '0;
    for (int k = 0; k < 768; k++) begin
      sent[k] = fbyte(k);
      while (gaps && $urandom_range(0, 1) == 1) begin
        beat(8'hF6, 1'b0, 1'b0);
        total++;
        if (o_frame_data_valid !== 1'b0 || o_frame_data !== last_d || o_row_cnt !== last_r || o_col_cnt !== last_c) begin
          bad++;
          $display("FAIL gap_hold k=%0d got v=%b d=%h r=%0d c=%0d, expected v=0 d=%h r=%0d c=%0d",
                   k, o_frame_data_valid, o_frame_data, o_row_cnt, o_col_cnt, last_d, last_r, last_c);
        end
      end
      beat(sent[k], 1'b1, 1'b0);
      ed = (k >= 5) ? sent[k - 5] : 8'h00;
      p  = (k >= 5) ? k - 5 : 0;
      er = 2'((p / 64) % 4);
      ec = 8'(p % 64);
      ef = (k == 261 || k == 517);
      ei = (k >= 261);
      total++;
      if (o_frame_data_valid !== 1'b1 || o_frame_data !== ed || o_row_cnt !== er || o_col_cnt !== ec ||
          o_frame_data_fas !== ef || o_in_frame !== ei) begin
        bad++;
        $display("FAIL lock gaps=%0d k=%0d got v=%b d=%h r=%0d c=%0d fas=%b inf=%b, expected v=1 d=%h r=%0d c=%0d fas=%b inf=%b",
                 gaps, k, o_frame_data_valid, o_frame_data, o_row_cnt, o_col_cnt, o_frame_data_fas, o_in_frame,
                 ed, er, ec, ef, ei);
      end
      last_d = ed; last_r = er; last_c = ec;
    end
  endtask

  task automatic test_false_lock();
    logic [47:0] w;
    logic saw_fas;
    w = 48'hF6F6F6282828;
    saw_fas = 1'b0;
    do_reset();
    for (int k = 0; k < 300; k++) begin
      if (k < 6) beat(w[47 - 8 * k -: 8], 1'b1, 1'b0);
      else beat(8'($urandom_range(0, 127)), 1'b1, 1'b0);
      if (o_frame_data_fas) saw_fas = 1'b1;
      if (k == 5) begin
        total++;
        if (o_frame_data !== 8'hF6 || o_row_cnt !== 2'd0 || o_col_cnt !== 8'd0 || o_in_frame !== 1'b0) begin
          bad++;
          $display("FAIL false_presync got d=%h r=%0d c=%0d inf=%b, expected d=f6 r=0 c=0 inf=0",
                   o_frame_data, o_row_cnt, o_col_cnt, o_in_frame);
        end
      end
      if (k == 200) begin
        total++;
        if (o_row_cnt !== 2'd3 || o_col_cnt !== 8'd3) begin
          bad++;
          $display("FAIL false_count got r=%0d c=%0d, expected r=3 c=3", o_row_cnt, o_col_cnt);
        end
      end
      if (k == 262) begin
        total++;
        if (o_row_cnt !== 2'd0 || o_col_cnt !== 8'd0 || o_in_frame !== 1'b0) begin
          bad++;
          $display("FAIL false_hunt got r=%0d c=%0d inf=%b, expected r=0 c=0 inf=0",
                   o_row_cnt, o_col_cnt, o_in_frame);
        end
      end
    end
    total++;
    if (saw_fas !== 1'b0) begin
      bad++;
      $display("FAIL false_fas got fas seen=%b, expected 0", saw_fas);
    end
  endtask

  task automatic test_oof();
    logic [7:0] fas_tab, in_tab;
    int f;
    fas_tab = 8'b0001_0010;
    in_tab  = 8'b0111_1110;
    bad_frames = 16'b0000_0000_1110_1100;
    do_reset();
    for (int k = 0; k < 1800; k++) begin
      beat(fbyte(k), 1'b1, 1'b0);
      if (k >= 261 && k % 256 == 5) begin
        f = k / 256;
        total++;
        if (o_frame_data_fas !== fas_tab[f] || o_in_frame !== in_tab[f] || o_row_cnt !== 2'd0 || o_col_cnt !== 8'd0) begin
          bad++;
          $display("FAIL oof frame=%0d got fas=%b inf=%b r=%0d c=%0d, expected fas=%b inf=%b r=0 c=0",
                   f, o_frame_data_fas, o_in_frame, o_row_cnt, o_col_cnt, fas_tab[f], in_tab[f]);
        end
      end else if (k > 261 && k < 1797 && o_in_frame !== 1'b1) begin
        total++;
        bad++;
        $display("FAIL oof_hold k=%0d got inf=%b, expected 1", k, o_in_frame);
      end
      if (k == 1799) begin
        total++;
        if (o_in_frame !== 1'b0 || o_row_cnt !== 2'd0 || o_col_cnt !== 8'd0) begin
          bad++;
          $display("FAIL oof_hunt got inf=%b r=%0d c=%0d, expected inf=0 r=0 c=0", o_in_frame, o_row_cnt, o_col_cnt);
        end
      end
    end
    bad_frames = '0;
  endtask

  task automatic test_reset_mid();
    bad_frames = '0;
    do_reset();
    for (int k = 0; k < 399; k++) beat(fbyte(k), 1'b1, 1'b0);
    total++;
    if (o_in_frame !== 1'b1 || o_row_cnt !== 2'd2) begin
      bad++;
      $display("FAIL mid_locked got inf=%b r=%0d, expected inf=1 r=2", o_in_frame, o_row_cnt);
    end
    beat(fbyte(399), 1'b1, 1'b1);
    total++;
    if ({o_frame_data, o_frame_data_valid, o_frame_data_fas, o_row_cnt, o_col_cnt, o_in_frame} !== '0) begin
      bad++;
      $display("FAIL mid_reset got d=%h v=%b fas=%b r=%0d c=%0d inf=%b, expected all 0",
               o_frame_data, o_frame_data_valid, o_frame_data_fas, o_row_cnt, o_col_cnt, o_in_frame);
    end
    for (int k = 400; k < 780; k++) begin
      beat(fbyte(k), 1'b1, 1'b0);
      if (k == 516 || k == 517) begin
        total++;
        if (o_in_frame !== 1'b0 || o_frame_data_fas !== 1'b0 || o_row_cnt !== 2'd0 || o_col_cnt !== 8'd0) begin
          bad++;
          $display("FAIL relock_presync k=%0d got inf=%b fas=%b r=%0d c=%0d, expected 0 0 0 0",
                   k, o_in_frame, o_frame_data_fas, o_row_cnt, o_col_cnt);
        end
      end
      if (k == 773) begin
        total++;
        if (o_in_frame !== 1'b1 || o_frame_data_fas !== 1'b1 || o_frame_data !== 8'hF6) begin
          bad++;
          $display("FAIL relock_sync got inf=%b fas=%b d=%h, expected inf=1 fas=1 d=f6",
                   o_in_frame, o_frame_data_fas, o_frame_data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock(1'b0);
    test_false_lock();
    test_oof();
    test_lock(1'b1);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
